// File: rtl/norm_scaler_pkg.sv
// Shared definitions for the norm_scaler normaliser.
//   state_t      : FSM encoding (IDLE / SHIFT / DONE)
//   MODE_*       : operating range select (reciprocal or sqrt core)
//   lo_*/hi_*    : convergence-interval bounds as functions of the fraction width
package norm_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_RECIP = 1'b0;
  localparam logic MODE_SQRT  = 1'b1;

  // Reciprocal core converges on [0.75, 1.5].
  function automatic int lo_recip(input int frac);
    return 3 << (frac - 2);
  endfunction

  function automatic int hi_recip(input int frac);
    return 3 << (frac - 1);
  endfunction

  // Sqrt core converges on [0.5, 2.0).
  function automatic int lo_sqrt(input int frac);
    return 1 << (frac - 1);
  endfunction

  function automatic int hi_sqrt(input int frac);
    return (1 << (frac + 1)) - 1;
  endfunction

endpackage

// File: rtl/norm_range_cmp.sv
// Range classifier for the normaliser working value.
//   x        : working value, W+1 bits unsigned
//   mode     : MODE_RECIP / MODE_SQRT
//   shr      : x above the upper bound, shift right
//   shl      : x below the lower bound, shift left
//   in_range : x inside [LO, HI]
//   step     : shift amount per iteration (1 recip, 2 sqrt)
module norm_range_cmp
  import norm_scaler_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int SHW  = 5
) (
  input  logic [W:0]     x,
  input  logic           mode,
  output logic           shr,
  output logic           shl,
  output logic           in_range,
  output logic [SHW-1:0] step
);

  localparam logic [W:0] LO_RECIP = (W+1)'(lo_recip(FRAC));
  localparam logic [W:0] HI_RECIP = (W+1)'(hi_recip(FRAC));
  localparam logic [W:0] LO_SQRT  = (W+1)'(lo_sqrt(FRAC));
  localparam logic [W:0] HI_SQRT  = (W+1)'(hi_sqrt(FRAC));

  logic [W:0] lo, hi;

  always_comb begin
    lo   = (mode == MODE_SQRT) ? LO_SQRT : LO_RECIP;
    hi   = (mode == MODE_SQRT) ? HI_SQRT : HI_RECIP;
    // Even step in sqrt mode keeps the total exponent adjustment halvable.
    step = (mode == MODE_SQRT) ? SHW'(2) : SHW'(1);
    shr      = (x > hi);
    shl      = (x < lo);
    in_range = !shr && !shl;
  end

endmodule

// File: rtl/norm_scaler.sv
// Iterative power-of-two normaliser in front of the Newton-Raphson cores.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : start pulse, sampled only in IDLE (with mode_i, x_i)
//   mode_i       : 0 reciprocal range, 1 sqrt range
//   x_i          : signed operand Qx.FRAC
//   ack_i        : consumer acknowledge, releases DONE
//   busy_o       : FSM not idle
//   done_o       : result valid, held until ack_i
//   err_o        : operand was <= 0 (qualified by done_o)
//   x_scaled_o   : normalised operand
//   shift_l_o/_r : accumulated left / right shift bits
// Every output is a flop; busy/done are registered from the next state.
module norm_scaler
  import norm_scaler_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 14,
  parameter int SHW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic [W-1:0]   x_i,
  input  logic           ack_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [W-1:0]   x_scaled_o,
  output logic [SHW-1:0] shift_l_o,
  output logic [SHW-1:0] shift_r_o
);

  state_t         state, nxt;
  logic [W:0]     x_w, x_nxt;       // extra MSB holds 2*B1 without overflow
  logic           mode_q, mode_nxt;
  logic [SHW-1:0] sl_nxt, sr_nxt, step;
  logic [W-1:0]   xs_nxt;
  logic           err_nxt;
  logic           shr, shl, in_rng;
  logic           x_pos;

  assign x_pos = !x_i[W-1] && (x_i != '0);

  norm_range_cmp #(.W(W), .FRAC(FRAC), .SHW(SHW)) u_cmp (
    .x        (x_w),
    .mode     (mode_q),
    .shr      (shr),
    .shl      (shl),
    .in_range (in_rng),
    .step     (step)
  );

  // State register, with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= nxt;
      busy_o <= (nxt != IDLE);
      done_o <= (nxt == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_i) nxt = x_pos ? SHIFT : DONE;
      SHIFT:   if (in_rng) nxt = DONE;
      DONE:    if (ack_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath next values; everything holds by default.
  always_comb begin
    x_nxt    = x_w;
    mode_nxt = mode_q;
    sl_nxt   = shift_l_o;
    sr_nxt   = shift_r_o;
    xs_nxt   = x_scaled_o;
    err_nxt  = err_o;
    case (state)
      IDLE: if (start_i) begin
        sl_nxt = '0;
        sr_nxt = '0;
        if (x_pos) begin
          x_nxt    = {1'b0, x_i};
          mode_nxt = mode_i;
          err_nxt  = 1'b0;
        end else begin
          xs_nxt  = '0;
          err_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (shr) begin
          x_nxt  = x_w >> step;   // logical: operand is positive
          sr_nxt = shift_r_o + step;
        end else if (shl) begin
          x_nxt  = x_w << step;
          sl_nxt = shift_l_o + step;
        end else begin
          xs_nxt = x_w[W-1:0];
        end
      end
      DONE: if (ack_i) err_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_w        <= '0;
      mode_q     <= MODE_RECIP;
      shift_l_o  <= '0;
      shift_r_o  <= '0;
      x_scaled_o <= '0;
      err_o      <= 1'b0;
    end else begin
      x_w        <= x_nxt;
      mode_q     <= mode_nxt;
      shift_l_o  <= sl_nxt;
      shift_r_o  <= sr_nxt;
      x_scaled_o <= xs_nxt;
      err_o      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_norm_scaler.sv
// Self-checking bench for norm_scaler (W=16, FRAC=14): directed test-plan
// cases, randomized operands against an arithmetic reference model,
// done hold / ack, start-while-busy and mid-operation reset.
module tb_norm_scaler;

  logic        clk = 1'b0;
  logic        rst, start_i, mode_i, ack_i;
  logic [15:0] x_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] x_scaled_o;
  logic [4:0]  shift_l_o, shift_r_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  norm_scaler #(.W(16), .FRAC(14), .SHW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .x_i        (x_i),
    .ack_i      (ack_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .x_scaled_o (x_scaled_o),
    .shift_l_o  (shift_l_o),
    .shift_r_o  (shift_r_o)
  );

  // Reference: scale by powers of two until the value lies in the interval.
  function automatic void model(input bit m, input int x, output int xs,
                                output int sl, output int sr, output bit err,
                                output int lat);
    int b1, lo, hi, k, v, n;
    b1 = 16384;
    lo = m ? b1 / 2 : (3 * b1) / 4;
    hi = m ? 2 * b1 - 1 : (3 * b1) / 2;
    k  = m ? 4 : 2;
    sl = 0; sr = 0; n = 0; v = x;
    if (x <= 0) begin
      err = 1'b1; xs = 0; lat = 1;
    end else begin
      err = 1'b0;
      while (v > hi) begin v = v / k; sr += (m ? 2 : 1); n++; end
      while (v < lo) begin v = v * k; sl += (m ? 2 : 1); n++; end
      xs = v; lat = n + 2;
    end
  endfunction

  // Pulse start and count edges until done_o (40 bounds any legal op).
  task automatic do_op(input bit m, input int x, output int lat);
    @(negedge clk);
    x_i = 16'(x); mode_i = m; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_ack();
    @(negedge clk); ack_i = 1'b1;
    @(negedge clk); ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; ack_i = 1'b0; x_i = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy_o, done_o, err_o, x_scaled_o, shift_l_o, shift_r_o} !== 29'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b xs=%0d sl=%0d sr=%0d, need all 0",
               busy_o, done_o, err_o, x_scaled_o, shift_l_o, shift_r_o);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bit m_t [7] = '{0, 0, 1, 1, 0, 1, 0};
    int x_t [7] = '{16384, 30000, 1024, 32767, 0, -5, 3};
    int xs_t[7] = '{16384, 15000, 16384, 32767, 0, 0, 12288};
    int sl_t[7] = '{0, 0, 4, 0, 0, 0, 12};
    int sr_t[7] = '{0, 1, 0, 0, 0, 0, 0};
    bit e_t [7] = '{0, 0, 0, 0, 1, 1, 0};
    int la_t[7] = '{2, 3, 4, 2, 1, 1, 14};
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(m_t[i], x_t[i], lat);
      n_total++;
      if (lat !== la_t[i] || int'(x_scaled_o) !== xs_t[i] || int'(shift_l_o) !== sl_t[i] ||
          int'(shift_r_o) !== sr_t[i] || err_o !== e_t[i])
        $display("FAIL directed[%0d] x=%0d m=%0d: got lat=%0d xs=%0d sl=%0d sr=%0d err=%b, need lat=%0d xs=%0d sl=%0d sr=%0d err=%b",
                 i, x_t[i], m_t[i], lat, x_scaled_o, shift_l_o, shift_r_o, err_o,
                 la_t[i], xs_t[i], sl_t[i], sr_t[i], e_t[i]);
      else n_pass++;
      do_ack();
    end
  endtask

  task automatic test_hold_ack();
    int lat;
    do_op(1'b0, 3072, lat);
    n_total++;
    if (lat !== 4) $display("FAIL hold_latency: got %0d need 4", lat);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (done_o !== 1'b1 || busy_o !== 1'b1 || x_scaled_o !== 16'd12288 || shift_l_o !== 5'd2)
        $display("FAIL hold_cycle%0d: got done=%b busy=%b xs=%0d sl=%0d, need 1 1 12288 2",
                 c, done_o, busy_o, x_scaled_o, shift_l_o);
      else n_pass++;
    end
    do_ack();
    n_total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 ||
        x_scaled_o !== 16'd12288 || shift_l_o !== 5'd2)
      $display("FAIL ack_release: got done=%b busy=%b err=%b xs=%0d sl=%0d, need 0 0 0 12288 2",
               done_o, busy_o, err_o, x_scaled_o, shift_l_o);
    else n_pass++;
  endtask

  task automatic test_random();
    int x, xs, sl, sr, lat, mlat;
    bit m, err;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: x = int'($urandom_range(1, 255));
        1: x = int'($urandom_range(1, 32767));
        2: x = -int'($urandom_range(0, 32768));
        default: x = int'($urandom_range(8000, 32767));
      endcase
      model(m, x, xs, sl, sr, err, mlat);
      do_op(m, x, lat);
      n_total++;
      if (lat !== mlat || int'(x_scaled_o) !== xs || int'(shift_l_o) !== sl ||
          int'(shift_r_o) !== sr || err_o !== err)
        $display("FAIL random[%0d] x=%0d m=%0d: got lat=%0d xs=%0d sl=%0d sr=%0d err=%b, need lat=%0d xs=%0d sl=%0d sr=%0d err=%b",
                 i, x, m, lat, x_scaled_o, shift_l_o, shift_r_o, err_o, mlat, xs, sl, sr, err);
      else n_pass++;
      do_ack();
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    // Start x=3 (12 steps), then pulse a second start mid-flight.
    @(negedge clk);
    x_i = 16'd3; mode_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (2) @(negedge clk);
    x_i = 16'd16384; mode_i = 1'b1; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 40) begin @(negedge clk); lat++; end
    n_total++;
    if (x_scaled_o !== 16'd12288 || shift_l_o !== 5'd12 || shift_r_o !== 5'd0 || err_o !== 1'b0)
      $display("FAIL busy_start_ignored: got xs=%0d sl=%0d sr=%0d err=%b done=%b, need 12288 12 0 0 1",
               x_scaled_o, shift_l_o, shift_r_o, err_o, done_o);
    else n_pass++;
    // start together with ack must also be ignored.
    @(negedge clk);
    ack_i = 1'b1; start_i = 1'b1; x_i = 16'd16384; mode_i = 1'b0;
    @(negedge clk);
    ack_i = 1'b0; start_i = 1'b0;
    n_total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL ack_start_ignored: got busy=%b done=%b, need 0 0", busy_o, done_o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL ack_start_idle: got busy=%b done=%b, need 0 0", busy_o, done_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen_done;
    @(negedge clk);
    x_i = 16'd3; mode_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({busy_o, done_o, err_o, x_scaled_o, shift_l_o, shift_r_o} !== 29'd0)
      $display("FAIL reset_mid: got busy=%b done=%b err=%b xs=%0d sl=%0d sr=%0d, need all 0",
               busy_o, done_o, err_o, x_scaled_o, shift_l_o, shift_r_o);
    else n_pass++;
    seen_done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done_o || busy_o) seen_done = 1'b1;
    end
    n_total++;
    if (seen_done !== 1'b0) $display("FAIL reset_no_done: got activity=1 need 0");
    else n_pass++;
    do_op(1'b0, 3, lat);
    n_total++;
    if (lat !== 14 || x_scaled_o !== 16'd12288 || shift_l_o !== 5'd12 || shift_r_o !== 5'd0)
      $display("FAIL reset_restart: got lat=%0d xs=%0d sl=%0d sr=%0d, need 14 12288 12 0",
               lat, x_scaled_o, shift_l_o, shift_r_o);
    else n_pass++;
    do_ack();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_ack();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
